motor_pwm_array: RTL and testbench

MOTOR_PWM_ARRAY -- requirements
Module: motor_pwm_array

---
 rtl/motor_pwm_pkg.sv | 14 +
 rtl/motor_pwm_channel.sv | 94 +++++++++
 rtl/motor_pwm_array.sv | 149 ++++++++++++++
 tb/tb_motor_pwm_array.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared defaults and width helper for the motor PWM array.
package motor_pwm_pkg;

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_CNT_W     = 16;
    localparam int unsigned DEF_PERIOD    = 1000;
    localparam int unsigned DEF_RAMP_STEP = 1;

    // Channel-index width; a single channel still needs a 1-bit select.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One motor channel: duty target, per-period ramp, PWM compare, high-cycle
// measurement and its single-entry pending slot.
module motor_pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_duty,
    input  logic             i_enable,
    input  logic             i_run,
    input  logic             i_boundary,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_smp_vld,
    input  logic             i_smp_last,
    input  logic             i_grant,
    output logic             o_pwm,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_meas,
    output logic             o_drop
);

    localparam logic [CNT_W-1:0] PER  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

    logic [CNT_W-1:0] r_tgt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_meas;
    logic             r_pwm;
    logic             r_pend;
    logic             r_drop;
    logic [CNT_W-1:0] w_duty;
    logic [CNT_W-1:0] w_act_nxt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic             w_latch;

    assign w_duty     = (i_wr_duty > PER) ? PER : i_wr_duty;
    assign w_hcnt_nxt = r_hcnt + CNT_W'(r_pwm);
    assign w_latch    = i_smp_vld & i_smp_last;

    always_comb begin
        w_act_nxt = r_act;
        if (!i_enable) begin
            w_act_nxt = '0;
        end else if (i_boundary) begin
            if (r_tgt > r_act) begin
                w_act_nxt = (r_tgt - r_act > STEP) ? r_act + STEP : r_tgt;
            end else if (r_act > r_tgt) begin
                w_act_nxt = (r_act - r_tgt > STEP) ? r_act - STEP : r_tgt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tgt  <= '0;
            r_act  <= '0;
            r_hcnt <= '0;
            r_meas <= '0;
            r_pwm  <= 1'b0;
            r_pend <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_tgt <= w_duty;
            end
            r_act  <= w_act_nxt;
            r_pwm  <= i_run & i_enable & (i_cnt < r_act);
            r_drop <= 1'b0;
            // Counts the registered output, so the sample for counter P-1 lands one cycle late.
            if (i_smp_vld) begin
                r_hcnt <= i_smp_last ? '0 : w_hcnt_nxt;
            end
            if (w_latch) begin
                r_pend <= 1'b1;
                r_meas <= w_hcnt_nxt;
                r_drop <= r_pend & ~i_grant;
            end else if (i_grant) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pwm     = r_pwm;
    assign o_pending = r_pend;
    assign o_meas    = r_meas;
    assign o_drop    = r_drop;

endmodule

// File: rtl/motor_pwm_array.sv
// Multi-channel motor PWM: shared period counter, duty writes, and a
// round-robin measurement output with a one-entry presentation register.
module motor_pwm_array
    import motor_pwm_pkg::*;
#(
    parameter  int unsigned NUM_CH    = DEF_NUM_CH,
    parameter  int unsigned CNT_W     = DEF_CNT_W,
    parameter  int unsigned PERIOD    = DEF_PERIOD,
    parameter  int unsigned RAMP_STEP = DEF_RAMP_STEP,
    localparam int unsigned ID_W      = id_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ID_W-1:0]   i_wr_ch,
    input  logic [CNT_W-1:0]  i_wr_duty,
    input  logic [NUM_CH-1:0] i_enable,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_period_start,
    output logic              o_wr_err,
    output logic              o_meas_valid,
    input  logic              i_meas_ready,
    output logic [ID_W-1:0]   o_meas_ch,
    output logic [CNT_W-1:0]  o_meas_value,
    output logic              o_meas_drop
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic              r_run;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_smp_vld;
    logic              r_smp_last;
    logic              r_wr_err;
    logic              r_mv;
    logic [ID_W-1:0]   r_mch;
    logic [CNT_W-1:0]  r_mval;
    logic [ID_W-1:0]   r_ptr;
    logic              w_boundary;
    logic              w_wr_acc;
    logic              w_ch_ok;
    logic              w_load;
    logic              w_gnt_vld;
    logic [ID_W-1:0]   w_gnt_ch;
    logic [ID_W-1:0]   w_scan;
    logic [NUM_CH-1:0] w_wr_sel;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_grant;
    logic [CNT_W-1:0]  w_meas [NUM_CH];

    assign o_wr_ready     = ~i_reset;
    assign w_wr_acc       = i_wr_valid & o_wr_ready;
    assign w_boundary     = r_run && (r_cnt == LAST);
    assign o_period_start = r_run && (r_cnt == '0);

    generate
        if (NUM_CH == (1 << ID_W)) begin : g_full_ids
            assign w_ch_ok = 1'b1;
        end else begin : g_part_ids
            assign w_ch_ok = (32'(i_wr_ch) < NUM_CH);
        end
    endgenerate

    // r_run holds the counter at 0 for the first cycle after reset release.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run      <= 1'b0;
            r_cnt      <= '0;
            r_smp_vld  <= 1'b0;
            r_smp_last <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            r_smp_vld  <= r_run;
            r_smp_last <= w_boundary;
            r_wr_err   <= w_wr_acc & ~w_ch_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_sel[g] = w_wr_acc && w_ch_ok && (i_wr_ch == ID_W'(g));
        assign w_grant[g]  = w_load && w_gnt_vld && (w_gnt_ch == ID_W'(g));

        motor_pwm_channel #(
            .CNT_W     (CNT_W),
            .PERIOD    (PERIOD),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_wr_en    (w_wr_sel[g]),
            .i_wr_duty  (i_wr_duty),
            .i_enable   (i_enable[g]),
            .i_run      (r_run),
            .i_boundary (w_boundary),
            .i_cnt      (r_cnt),
            .i_smp_vld  (r_smp_vld),
            .i_smp_last (r_smp_last),
            .i_grant    (w_grant[g]),
            .o_pwm      (o_pwm[g]),
            .o_pending  (w_pend[g]),
            .o_meas     (w_meas[g]),
            .o_drop     (w_drop[g])
        );
    end

    always_comb begin
        w_load    = ~r_mv | i_meas_ready;
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_scan    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_scan = ID_W'((32'(r_ptr) + i) % NUM_CH);
            if (!w_gnt_vld && w_pend[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_scan;
            end
        end
    end

    // A granted channel's slot is freed on transfer here, so a later latch for it waits behind.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mv   <= 1'b0;
            r_mch  <= '0;
            r_mval <= '0;
            r_ptr  <= '0;
        end else if (w_load) begin
            r_mv <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_mch  <= w_gnt_ch;
                r_mval <= w_meas[w_gnt_ch];
                r_ptr  <= (32'(w_gnt_ch) == NUM_CH - 1) ? '0 : w_gnt_ch + ID_W'(1);
            end
        end
    end

    assign o_wr_err     = r_wr_err;
    assign o_meas_valid = r_mv;
    assign o_meas_ch    = r_mch;
    assign o_meas_value = r_mval;
    assign o_meas_drop  = |w_drop;

endmodule

// File: tb/tb_motor_pwm_array.sv
// Self-checking bench for motor_pwm_array: behavioural period model plus
// directed scenarios with literal expectations.
module tb_motor_pwm_array;

    localparam int NCH  = 4;
    localparam int CW   = 16;
    localparam int P    = 100;
    localparam int STEP = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_duty;
    logic [3:0]    en;
    logic [3:0]    pwm;
    logic          ps;
    logic          wr_err;
    logic          mv;
    logic          meas_ready;
    logic [1:0]    mch;
    logic [CW-1:0] mval;
    logic          mdrop;

    logic          d2_wr_valid;
    logic          d2_wr_ready;
    logic [1:0]    d2_wr_ch;
    logic [CW-1:0] d2_wr_duty;
    logic [2:0]    d2_en;
    logic [2:0]    d2_pwm;
    logic          d2_ps;
    logic          d2_err;
    logic          d2_mv;
    logic [1:0]    d2_mch;
    logic [CW-1:0] d2_mval;
    logic          d2_drop;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    motor_pwm_array #(.NUM_CH(NCH), .CNT_W(CW), .PERIOD(P), .RAMP_STEP(STEP)) dut (
        .i_clk(clk), .i_reset(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_ch(wr_ch), .i_wr_duty(wr_duty), .i_enable(en), .o_pwm(pwm),
        .o_period_start(ps), .o_wr_err(wr_err), .o_meas_valid(mv),
        .i_meas_ready(meas_ready), .o_meas_ch(mch), .o_meas_value(mval),
        .o_meas_drop(mdrop)
    );

    motor_pwm_array #(.NUM_CH(3), .CNT_W(CW), .PERIOD(P), .RAMP_STEP(STEP)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_wr_valid(d2_wr_valid), .o_wr_ready(d2_wr_ready),
        .i_wr_ch(d2_wr_ch), .i_wr_duty(d2_wr_duty), .i_enable(d2_en), .o_pwm(d2_pwm),
        .o_period_start(d2_ps), .o_wr_err(d2_err), .o_meas_valid(d2_mv),
        .i_meas_ready(1'b1), .o_meas_ch(d2_mch), .o_meas_value(d2_mval),
        .o_meas_drop(d2_drop)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: time-stepped period arithmetic per channel.
    int       m_cnt;
    bit       m_run;
    int       m_tgt[NCH];
    int       m_act[NCH];
    int       m_sum[NCH];
    int       m_latest[NCH];
    logic [3:0] m_pwm;
    bit       m_ps;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_pwm = '0;
            for (int k = 0; k < NCH; k++) begin
                m_tgt[k] = 0; m_act[k] = 0; m_sum[k] = 0; m_latest[k] = 0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int d;
                m_pwm[k] = m_run && en[k] && (m_cnt < m_act[k]);
                if (m_run) begin
                    m_sum[k] += int'(m_pwm[k]);
                    if (m_cnt == P - 1) begin
                        m_latest[k] = m_sum[k];
                        m_sum[k] = 0;
                    end
                end
                d = m_tgt[k] - m_act[k];
                if (d > STEP) d = STEP;
                if (d < -STEP) d = -STEP;
                if (!en[k]) m_act[k] = 0;
                else if (m_run && m_cnt == P - 1) m_act[k] += d;
            end
            if (wr_valid) m_tgt[int'(wr_ch)] = (int'(wr_duty) > P) ? P : int'(wr_duty);
            if (!m_run) m_run = 1'b1;
            else m_cnt = (m_cnt + 1) % P;
        end
        m_ps = m_run && (m_cnt == 0);
    end

    int hist[NCH][128];
    int nhist[NCH];
    int log_ch[1024];
    int log_val[1024];
    int nlog = 0;
    bit prev_hold = 1'b0;
    logic [1:0]    prev_ch;
    logic [CW-1:0] prev_val;

    always @(negedge clk) begin
        #1;
        if (chk_on) begin
            chk("pwm", pwm, m_pwm);
            chk("period_start", ps, m_ps);
            chk("wr_ready", wr_ready, !rst);
            chk("wr_err", wr_err, 0);
            if (prev_hold) begin
                chk("meas_valid_hold", mv, 1);
                chk("meas_ch_hold", mch, prev_ch);
                chk("meas_value_hold", mval, prev_val);
            end
            if (mv && meas_ready && !rst) begin
                chk("meas_value", mval, m_latest[int'(mch)]);
                if (nhist[mch] < 128) begin
                    hist[mch][nhist[mch]] = int'(mval);
                    nhist[mch]++;
                end
                if (nlog < 1024) begin
                    log_ch[nlog] = int'(mch);
                    log_val[nlog] = int'(mval);
                    nlog++;
                end
            end
            prev_hold = mv && !meas_ready && !rst;
            prev_ch   = mch;
            prev_val  = mval;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int duty);
        wr_valid = 1'b1;
        wr_ch    = 2'(ch);
        wr_duty  = CW'(duty);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ps && k < 250);
        chk("period_start_wait", ps, 1);
    endtask

    task automatic count_high(input int k, output int n);
        n = 0;
        repeat (P) begin
            n += int'(pwm[k]);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, drops, base;
        rst = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0; en = '0; meas_ready = 1'b1;
        d2_wr_valid = 1'b0; d2_wr_ch = '0; d2_wr_duty = '0; d2_en = '0;
        for (int k = 0; k < NCH; k++) nhist[k] = 0;
        tick(3);
        chk_on = 1'b1;
        chk("rst_pwm", pwm, 0);
        chk("rst_period_start", ps, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_meas_valid", mv, 0);
        chk("rst_meas_ch", mch, 0);
        chk("rst_meas_value", mval, 0);
        chk("rst_meas_drop", mdrop, 0);

        // Ramp ch0 to 50 in steps of 10.
        rst = 1'b0;
        en  = 4'b0001;
        wr(0, 50);
        chk("first_period_start", ps, 1);
        d2_en = 3'b111;
        d2_wr_valid = 1'b1; d2_wr_ch = 2'd3; d2_wr_duty = CW'(50);
        @(negedge clk);
        d2_wr_valid = 1'b0;
        chk("invalid_ch_err_pulse", d2_err, 1);
        @(negedge clk);
        chk("invalid_ch_err_single", d2_err, 0);
        repeat (5) wait_ps();
        n = 0; n2 = 0;
        repeat (P) begin
            n  += int'(pwm[0]);
            n2 += int'(d2_pwm != 3'b000);
            @(negedge clk);
        end
        chk("ch0_high_cycles_p6", n, 50);
        chk("invalid_write_no_pwm", n2, 0);
        wait_ps();
        tick(10);
        chk("ch0_meas_p1", hist[0][0], 0);
        chk("ch0_meas_p2", hist[0][1], 10);
        chk("ch0_meas_p3", hist[0][2], 20);
        chk("ch0_meas_p4", hist[0][3], 30);
        chk("ch0_meas_p5", hist[0][4], 40);
        chk("ch0_meas_p6", hist[0][5], 50);

        // Clamp ch1 to full period; bring the other channels up too.
        wr(1, 150);
        wr(2, 30);
        wr(3, 20);
        en = 4'b1111;
        repeat (12) wait_ps();
        count_high(1, n);
        chk("ch1_constant_high", n, 100);
        tick(10);
        chk("ch1_meas_clamped", hist[1][nhist[1] - 1], 100);

        // Backpressure for three periods.
        wait_ps();
        meas_ready = 1'b0;
        base = nlog;
        drops = 0;
        repeat (3 * P) begin
            @(negedge clk);
            drops += int'(mdrop);
        end
        chk("hold_no_transfer", nlog - base, 0);
        chk("hold_valid", mv, 1);
        chk("hold_ch", mch, 0);
        chk("hold_value", mval, 50);
        chk("drop_pulses", drops, 2);
        meas_ready = 1'b1;
        tick(10);
        chk("rr_ch_0", log_ch[base], 0);
        chk("rr_val_0", log_val[base], 50);
        chk("rr_ch_1", log_ch[base + 1], 1);
        chk("rr_val_1", log_val[base + 1], 100);
        chk("rr_ch_2", log_ch[base + 2], 2);
        chk("rr_val_2", log_val[base + 2], 30);
        chk("rr_ch_3", log_ch[base + 3], 3);
        chk("rr_val_3", log_val[base + 3], 20);

        // Disable ch2 mid-period, then soft-start it to 40.
        wait_ps();
        tick(10);
        en[2] = 1'b0;
        @(negedge clk);
        chk("ch2_off_next_cycle", pwm[2], 0);
        wait_ps();
        wr(2, 40);
        tick(9);
        base = nhist[2];
        en[2] = 1'b1;
        repeat (5) wait_ps();
        tick(10);
        chk("ch2_reen_p0", hist[2][base], 0);
        chk("ch2_reen_p1", hist[2][base + 1], 10);
        chk("ch2_reen_p2", hist[2][base + 2], 20);
        chk("ch2_reen_p3", hist[2][base + 3], 30);
        chk("ch2_reen_p4", hist[2][base + 4], 40);

        // Reset at counter 57.
        wait_ps();
        tick(57);
        chk("pre_reset_ch1_high", pwm[1], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pwm", pwm, 0);
        chk("midrst_period_start", ps, 0);
        chk("midrst_wr_ready", wr_ready, 0);
        chk("midrst_wr_err", wr_err, 0);
        chk("midrst_meas_valid", mv, 0);
        chk("midrst_meas_ch", mch, 0);
        chk("midrst_meas_value", mval, 0);
        chk("midrst_meas_drop", mdrop, 0);
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("release_period_start", ps, 1);
        @(negedge clk);
        chk("release_period_start_once", ps, 0);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
